// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the 256x16 instruction memory.
// Receives a framed byte stream (length, N {hi,lo} word pairs, XOR checksum),
// writes the assembled words from address 0 upward and holds the CPU in reset
// until a load finishes with a matching checksum.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               pulse that begins a load (honoured in IDLE or DONE)
//   rx_data, rx_valid   incoming byte stream
//   rx_ready            byte accepted when rx_valid && rx_ready at a clk edge
//   wr_en/addr/data     instruction memory write port, one strobe per word
//   busy                load in progress
//   done                load finished (sticky until next start or reset)
//   err                 checksum mismatch on the last load, valid with done
//   cpu_hold            CPU reset request, low only after a good load
module imem_loader #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               cpu_hold
);

    localparam int unsigned BYTE_W = 8;
    // One extra bit so a full-depth load (length byte 0) is representable.
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CHK   = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [BYTE_W-1:0]   chk_q, chk_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;

    logic                rx_ready_q, rx_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [INSTR_W-1:0]  wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                cpu_hold_q, cpu_hold_d;

    logic                accept_c;

    // A byte transfers only when the registered ready meets valid.
    assign accept_c = rx_valid && rx_ready_q;

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            chk_q      <= '0;
            hi_q       <= '0;
            rx_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            chk_q      <= chk_d;
            hi_q       <= hi_d;
            rx_ready_q <= rx_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        chk_d   = chk_q;
        hi_d    = hi_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept_c) begin
                    count_d = (rx_data == '0) ? CNT_W'(1 << ADDR_W) : CNT_W'(rx_data);
                    addr_d  = '0;
                    chk_d   = '0;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (accept_c) begin
                    hi_d    = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept_c) begin
                    chk_d   = chk_q ^ rx_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q - CNT_W'(1);
                state_d = (count_q == CNT_W'(1)) ? S_CHK : S_HI;
            end
            S_CHK: begin
                if (accept_c) state_d = S_DONE;
            end
            S_DONE: begin
                if (start) state_d = S_LEN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs, decoded from the state being entered.
    always_comb begin
        rx_ready_d = (state_d == S_LEN) || (state_d == S_HI) ||
                     (state_d == S_LO)  || (state_d == S_CHK);
        wr_en_d    = (state_d == S_WRITE);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        wr_addr_d  = (state_d == S_WRITE) ? addr_q : wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        err_d      = err_q;

        if (state_q == S_LO && accept_c) begin
            wr_data_d = INSTR_W'({hi_q, rx_data});
        end
        if (state_q == S_CHK && accept_c) begin
            done_d = 1'b1;
            err_d  = (rx_data != chk_q);
        end
        if (state_q == S_DONE && start) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end

        // CPU is released only while sitting in DONE after a good checksum.
        cpu_hold_d = !((state_d == S_DONE) && !err_d);
    end

    assign rx_ready = rx_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_hold = cpu_hold_q;

endmodule
